// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - state encoding and default widths for the trace capture controller
package trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } capture_state_e;

  localparam int COUNT_WIDTH_DEF = 16;
  localparam int LAT_WIDTH_DEF   = 32;

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// rtl/trace_capture_ctrl_if.sv - capture FIFO write port between the controller and the FIFO
interface trace_capture_ctrl_if;

  logic       fifo_wr;
  logic [7:0] fifo_data;
  logic       fifo_full;

  modport master (
    output fifo_wr,
    output fifo_data,
    input  fifo_full
  );

  modport slave (
    input  fifo_wr,
    input  fifo_data,
    output fifo_full
  );

endinterface

// File: rtl/trace_nibble_packer.sv
// rtl/trace_nibble_packer.sv - pairs TRACEDATA nibbles into bytes, first nibble in the low half
module trace_nibble_packer
  import trace_capture_pkg::*;
(
  input  logic       target_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] trace_data,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic       phase;
  logic [3:0] low_nibble;

  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      phase      <= 1'b0;
      low_nibble <= 4'h0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (enable) begin
      if (!phase)
        low_nibble <= trace_data;
      phase <= ~phase;
    end
  end

  // The byte is complete on the edge that samples the high nibble.
  assign byte_valid = enable & phase & ~clear;
  assign byte_data  = {trace_data, low_nibble};

endmodule

// File: rtl/trace_capture_ctrl.sv
// rtl/trace_capture_ctrl.sv - arms on request, starts on trigger edge, packs and writes trace bytes
module trace_capture_ctrl
  import trace_capture_pkg::*;
#(
  parameter int pCOUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int pLAT_WIDTH   = LAT_WIDTH_DEF
) (
  input  logic                    target_clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trigger,
  input  logic [pCOUNT_WIDTH-1:0] capture_len,
  input  logic [3:0]              trace_data,
  trace_capture_ctrl_if.master    fifo,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    overflow,
  output logic [pCOUNT_WIDTH-1:0] byte_count,
  output logic [pLAT_WIDTH-1:0]   trig_latency
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARMED   = ST_ARMED;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DONE    = ST_DONE;

  localparam logic [pCOUNT_WIDTH-1:0] COUNT_ONE = pCOUNT_WIDTH'(1);
  localparam logic [pLAT_WIDTH-1:0]   LAT_ONE   = pLAT_WIDTH'(1);

  logic                    trigger_q;
  logic                    trig_edge;
  logic [pCOUNT_WIDTH-1:0] len_r;
  logic [pCOUNT_WIDTH-1:0] next_count;
  logic                    pack_en;
  logic                    pack_clr;
  logic                    byte_valid;
  logic [7:0]              byte_data;

  assign trig_edge  = trigger & ~trigger_q;
  assign next_count = byte_count + COUNT_ONE;
  assign pack_en    = (state == S_CAPTURE) & ~abort;
  // Outside CAPTURE the packer is held at phase 0 so capture always starts on a low nibble.
  assign pack_clr   = abort | (state != S_CAPTURE);

  trace_nibble_packer u_packer (
    .target_clk (target_clk),
    .reset      (reset),
    .enable     (pack_en),
    .clear      (pack_clr),
    .trace_data (trace_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      trigger_q      <= 1'b0;
      len_r          <= '0;
      byte_count     <= '0;
      overflow       <= 1'b0;
      trig_latency   <= '0;
      done           <= 1'b0;
      fifo.fifo_wr   <= 1'b0;
      fifo.fifo_data <= 8'h00;
    end else begin
      trigger_q    <= trigger;
      fifo.fifo_wr <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              len_r        <= capture_len;
              byte_count   <= '0;
              overflow     <= 1'b0;
              trig_latency <= '0;
              if (capture_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_ARMED;
              end
            end
          end
          S_ARMED: begin
            if (trig_latency != '1)
              trig_latency <= trig_latency + LAT_ONE;
            if (trig_edge)
              state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (byte_valid) begin
              byte_count <= next_count;
              if (!fifo.fifo_full) begin
                fifo.fifo_wr   <= 1'b1;
                fifo.fifo_data <= byte_data;
              end else begin
                overflow <= 1'b1;
              end
              if (next_count == len_r) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb/tb_trace_capture_ctrl.sv - randomized self-checking bench for trace_capture_ctrl
module tb_trace_capture_ctrl;

  logic        target_clk = 1'b0;
  logic        reset      = 1'b0;
  logic        arm        = 1'b0;
  logic        abort      = 1'b0;
  logic        trigger    = 1'b0;
  logic [15:0] capture_len = 16'd0;
  logic [3:0]  trace_data  = 4'd0;
  logic [1:0]  state;
  logic        done;
  logic        overflow;
  logic [15:0] byte_count;
  logic [31:0] trig_latency;

  trace_capture_ctrl_if fifo_if ();

  trace_capture_ctrl dut (
    .target_clk   (target_clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .capture_len  (capture_len),
    .trace_data   (trace_data),
    .fifo         (fifo_if.master),
    .state        (state),
    .done         (done),
    .overflow     (overflow),
    .byte_count   (byte_count),
    .trig_latency (trig_latency)
  );

  always #5 target_clk = ~target_clk;

  int cyc = 0;
  always @(posedge target_clk) cyc <= cyc + 1;

  // Observed FIFO writes and done pulses, stamped with the index of the edge that produced them.
  int         wr_cyc_q[$];
  logic [7:0] wr_dat_q[$];
  int         done_q[$];
  int         b2b = 0;
  logic       prev_wr = 1'b0;

  always @(negedge target_clk) begin
    if (fifo_if.fifo_wr === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_dat_q.push_back(fifo_if.fifo_data);
      if (prev_wr === 1'b1) b2b++;
    end
    if (done === 1'b1) done_q.push_back(cyc);
    prev_wr = fifo_if.fifo_wr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge target_clk);
    #1;
  endtask

  logic [3:0] nib[64];
  bit         full_b[32];

  // trig_mode 0: trigger low at arm; 1: high before arm; 2: rises with arm. lat = cycles spent ARMED.
  task automatic run_capture(input int len, input int lat, input int trig_mode, input int abort_at);
    int         wr_base, done_base, n_cyc, nib_edges, nb, n_wr;
    bit         exp_ovf;
    int         exp_cyc[$];
    logic [7:0] exp_dat[$];
    wr_base   = wr_cyc_q.size();
    done_base = done_q.size();
    if (trig_mode == 1) begin
      trigger = 1'b1;
      tick();
    end
    fifo_if.fifo_full = 1'b0;
    arm         = 1'b1;
    capture_len = 16'(len);
    trigger     = (trig_mode != 0);
    tick();
    arm         = 1'b0;
    capture_len = 16'($urandom);
    check("arm_state", state, (len == 0) ? 2'd3 : 2'd1);
    if (len == 0) begin
      check("zero_len_done", done, 1'b1);
      tick();
      check("zero_len_done_once", done, 1'b0);
      check("zero_len_no_wr", wr_cyc_q.size() - wr_base, 0);
      check("zero_len_count", byte_count, 0);
      return;
    end
    for (int i = 1; i < lat; i++) begin
      trigger     = (trig_mode != 0) ? (i != lat - 1) : 1'b0;
      arm         = ($urandom_range(4) == 0);
      capture_len = 16'($urandom);
      trace_data  = 4'($urandom);
      tick();
      check("armed_hold", state, 2'd1);
    end
    arm     = 1'b0;
    trigger = 1'b1;
    tick();
    n_cyc = cyc;
    check("capture_state", state, 2'd2);
    nib_edges = (abort_at >= 0) ? abort_at : 2 * len;
    for (int e = 0; e < nib_edges; e++) begin
      trace_data        = nib[e];
      fifo_if.fifo_full = (e % 2 == 1) ? full_b[e / 2] : 1'($urandom);
      trigger           = 1'($urandom);
      arm               = ($urandom_range(5) == 0);
      capture_len       = 16'($urandom);
      tick();
    end
    arm               = 1'b0;
    fifo_if.fifo_full = 1'b0;
    if (abort_at >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", state, 2'd0);
      for (int i = 0; i < 3; i++) begin
        trigger    = 1'($urandom);
        trace_data = 4'($urandom);
        tick();
      end
      check("abort_still_idle", state, 2'd0);
      check("abort_no_done", done_q.size() - done_base, 0);
    end else begin
      check("done_state", state, 2'd3);
      check("done_pulse", done, 1'b1);
      tick();
      check("done_once", done, 1'b0);
      check("done_count", done_q.size() - done_base, 1);
      if (done_q.size() > done_base)
        check("done_cycle", done_q[done_base], n_cyc + 2 * len);
    end
    nb      = nib_edges / 2;
    exp_ovf = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (!full_b[k]) begin
        exp_cyc.push_back(n_cyc + 2 * k + 2);
        exp_dat.push_back({nib[2 * k + 1], nib[2 * k]});
      end
      exp_ovf |= full_b[k];
    end
    n_wr = wr_cyc_q.size() - wr_base;
    check("wr_count", n_wr, exp_cyc.size());
    for (int k = 0; k < n_wr && k < exp_cyc.size(); k++) begin
      check("wr_cycle", wr_cyc_q[wr_base + k], exp_cyc[k]);
      check("wr_data", wr_dat_q[wr_base + k], exp_dat[k]);
    end
    check("byte_count", byte_count, nb);
    check("overflow", overflow, exp_ovf);
    check("trig_latency", trig_latency, lat);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 2'd0);
    check({tag, "_wr"}, fifo_if.fifo_wr, 1'b0);
    check({tag, "_data"}, fifo_if.fifo_data, 8'h00);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_count"}, byte_count, 0);
    check({tag, "_lat"}, trig_latency, 0);
  endtask

  task automatic fill_random(input int full_pct);
    for (int i = 0; i < 64; i++) nib[i] = 4'($urandom);
    for (int i = 0; i < 32; i++) full_b[i] = ($urandom_range(99) < full_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, wr_base;
    fifo_if.fifo_full = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    @(negedge target_clk);
    reset = 1'b1;
    tick();
    check_reset_values("post_reset");

    for (int i = 0; i < 8; i++) nib[i] = 4'(i + 1);
    for (int i = 0; i < 32; i++) full_b[i] = 1'b0;
    run_capture(4, 10, 0, -1);
    full_b[1] = 1'b1;
    run_capture(4, 10, 0, -1);

    fill_random(0);
    run_capture(8, 6, 0, 4);

    run_capture(0, 1, 0, -1);
    fill_random(0);
    run_capture(2, 3, 0, -1);

    fill_random(20);
    run_capture(2, 8, 1, -1);
    fill_random(20);
    run_capture(3, 5, 2, -1);

    // Asynchronous reset right after the first (low) nibble of a capture.
    wr_base = wr_cyc_q.size();
    arm         = 1'b1;
    capture_len = 16'd3;
    trigger     = 1'b0;
    tick();
    arm     = 1'b0;
    trigger = 1'b1;
    tick();
    check("rst_cap_state", state, 2'd2);
    trace_data = 4'hA;
    tick();
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trace_data = 4'($urandom);
      trigger    = 1'($urandom);
      tick();
    end
    check("rst_no_stray_wr", wr_cyc_q.size() - wr_base, 0);
    check("rst_stays_idle", state, 2'd0);

    for (int t = 0; t < 25; t++) begin
      int mode, lat, ab;
      len  = $urandom_range(10, 1);
      mode = $urandom_range(2);
      lat  = (mode == 0) ? $urandom_range(15, 1) : $urandom_range(15, 2);
      ab   = ($urandom_range(3) == 0) ? $urandom_range(2 * len - 1) : -1;
      fill_random(25);
      run_capture(len, lat, mode, ab);
    end

    check("no_back_to_back_wr", b2b, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
